// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_pkg
// Purpose  : Shared loader constants and FSM state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_IDX_W     = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_WRITE   = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/imem_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader_if
// Purpose  : Byte-stream input and instruction-memory write bundle of the loader.
// Revision : 1.0 - initial release
// ============================================================================
interface imem_loader_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
);
    logic                  start;
    logic                  byte_valid;
    logic [7:0]            byte_data;
    logic                  last;
    logic                  byte_ready;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic                  busy;
    logic                  done;
    logic                  overflow;
    logic [ADDR_WIDTH:0]   word_count;

    // master = program source / host, slave = loader
    modport master (
        output start, byte_valid, byte_data, last,
        input  byte_ready, we, addr, data, busy, done, overflow, word_count
    );

    modport slave (
        input  start, byte_valid, byte_data, last,
        output byte_ready, we, addr, data, busy, done, overflow, word_count
    );
endinterface
`default_nettype wire

// File: rtl/word_assembler.sv
`default_nettype none
// ============================================================================
// Module   : word_assembler
// Purpose  : Packs accepted bytes big-endian into a word; a new word starts zeroed.
// Revision : 1.0 - initial release
// ============================================================================
module word_assembler
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  wire logic                  i_clk,
    input  wire logic                  i_rst_n,
    input  wire logic                  i_clear,
    input  wire logic                  i_accept,
    input  wire logic [BYTE_IDX_W-1:0] i_byte_idx,
    input  wire logic [7:0]            i_byte,
    output logic      [DATA_WIDTH-1:0] o_word_next
);

    logic [DATA_WIDTH-1:0] word_q;
    logic [DATA_WIDTH-1:0] word_d;

    // Lane 0 overwrites the whole word, so a short final word is zero-padded.
    always_comb begin
        word_d = word_q;
        if (i_clear) begin
            word_d = '0;
        end else if (i_accept) begin
            case (i_byte_idx)
                2'd0:    word_d = {i_byte, 24'h000000};
                2'd1:    word_d[23:16] = i_byte;
                2'd2:    word_d[15:8]  = i_byte;
                default: word_d[7:0]   = i_byte;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            word_q <= '0;
        end else begin
            word_q <= word_d;
        end
    end

    assign o_word_next = word_d;

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Purpose  : Loads a byte-stream program into instruction memory, one word per write.
// Revision : 1.0 - initial release
// ============================================================================
module imem_loader
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  wire logic                  i_clk,
    input  wire logic                  i_rst_n,
    input  wire logic                  i_start,
    input  wire logic                  i_byte_valid,
    input  wire logic [7:0]            i_byte,
    input  wire logic                  i_last,
    output logic                       o_byte_ready,
    output logic                       o_we,
    output logic      [ADDR_WIDTH-1:0] o_addr,
    output logic      [DATA_WIDTH-1:0] o_data,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_overflow,
    output logic      [ADDR_WIDTH:0]   o_word_count
);

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [BYTE_IDX_W-1:0]   byte_idx_q, byte_idx_d;
    logic [ADDR_WIDTH:0]     count_q, count_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    last_q, last_d;
    logic                    overflow_q, overflow_d;

    logic                    w_accept;
    logic                    w_clear;
    logic                    w_word_end;
    logic [DATA_WIDTH-1:0]   w_word_next;

    assign w_accept   = i_byte_valid && (state_q == ST_COLLECT);
    assign w_clear    = i_start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign w_word_end = w_accept &&
                        ((byte_idx_q == BYTE_IDX_W'(BYTES_PER_WORD - 1)) || i_last);

    word_assembler #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_word_assembler (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_clear     (w_clear),
        .i_accept    (w_accept),
        .i_byte_idx  (byte_idx_q),
        .i_byte      (i_byte),
        .o_word_next (w_word_next)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (i_start) state_d = ST_COLLECT;
            ST_COLLECT: if (w_word_end) state_d = ST_WRITE;
            ST_WRITE:   state_d = (last_q || (&addr_q)) ? ST_DONE : ST_COLLECT;
            ST_DONE:    if (i_start) state_d = ST_COLLECT;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        o_byte_ready = (state_q == ST_COLLECT);
        o_we         = (state_q == ST_WRITE);
        o_busy       = (state_q == ST_COLLECT) || (state_q == ST_WRITE);
        o_done       = (state_q == ST_DONE);
    end

    // The output word is captured on the final byte so it stays frozen between writes.
    always_comb begin
        addr_d     = addr_q;
        byte_idx_d = byte_idx_q;
        count_d    = count_q;
        data_d     = data_q;
        last_d     = last_q;
        overflow_d = overflow_q;
        if (w_clear) begin
            addr_d     = '0;
            byte_idx_d = '0;
            count_d    = '0;
            last_d     = 1'b0;
            overflow_d = 1'b0;
        end
        if (w_accept) begin
            last_d     = i_last;
            byte_idx_d = w_word_end ? '0 : byte_idx_q + 1'b1;
            if (w_word_end) begin
                data_d = w_word_next;
            end
        end
        if (state_q == ST_WRITE) begin
            count_d = count_q + 1'b1;
            if (!last_q) begin
                if (&addr_q) begin
                    overflow_d = 1'b1;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            addr_q     <= '0;
            byte_idx_q <= '0;
            count_q    <= '0;
            data_q     <= '0;
            last_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            byte_idx_q <= byte_idx_d;
            count_q    <= count_d;
            data_q     <= data_d;
            last_q     <= last_d;
            overflow_q <= overflow_d;
        end
    end

    assign o_addr       = addr_q;
    assign o_data       = data_q;
    assign o_overflow   = overflow_q;
    assign o_word_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_loader
// Purpose  : Randomized scoreboard bench for imem_loader against a packing model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    localparam int AW  = 2;
    localparam int DW  = 32;
    localparam int CAP = 1 << AW;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    imem_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    imem_loader #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (bus.start),
        .i_byte_valid (bus.byte_valid),
        .i_byte       (bus.byte_data),
        .i_last       (bus.last),
        .o_byte_ready (bus.byte_ready),
        .o_we         (bus.we),
        .o_addr       (bus.addr),
        .o_data       (bus.data),
        .o_busy       (bus.busy),
        .o_done       (bus.done),
        .o_overflow   (bus.overflow),
        .o_word_count (bus.word_count)
    );

    int          n_chk  = 0;
    int          n_fail = 0;
    int          exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    logic [31:0] last_data;
    logic [7:0]  prog[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write must match the next expected word; otherwise data holds.
    always @(negedge clk) begin
        if (!rst_n) begin
            last_data = 32'h0;
        end else if (bus.we) begin
            if (exp_data_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %0h data %h, expected no write",
                         bus.addr, bus.data);
            end else begin
                int          a;
                logic [31:0] d;
                a = exp_addr_q.pop_front();
                d = exp_data_q.pop_front();
                chk("write_addr", 64'(bus.addr), 64'(a));
                chk("write_data", 64'(bus.data), 64'(d));
                last_data = d;
            end
        end else begin
            chk("data_hold", 64'(bus.data), 64'(last_data));
        end
    end

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_ready"},    64'(bus.byte_ready), 0);
        chk({tag, "_we"},       64'(bus.we), 0);
        chk({tag, "_addr"},     64'(bus.addr), 0);
        chk({tag, "_data"},     64'(bus.data), 0);
        chk({tag, "_busy"},     64'(bus.busy), 0);
        chk({tag, "_done"},     64'(bus.done), 0);
        chk({tag, "_overflow"}, 64'(bus.overflow), 0);
        chk({tag, "_count"},    64'(bus.word_count), 0);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Random gaps carry junk i_last and a start pulse that a busy loader must ignore.
    task automatic send_byte(input logic [7:0] b, input bit lst, output bit acc);
        int gaps;
        gaps = $urandom_range(0, 2);
        acc  = 1'b0;
        for (int g = 0; g < gaps; g++) begin
            @(negedge clk);
            bus.byte_valid = 1'b0;
            bus.last       = 1'($urandom_range(0, 1));
            bus.byte_data  = 8'($urandom);
            bus.start      = bus.busy ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            bus.start      = 1'b0;
            bus.byte_valid = 1'b1;
            bus.byte_data  = b;
            bus.last       = lst;
            if (bus.byte_ready) begin
                @(posedge clk);
                #1;
                acc = 1'b1;
                break;
            end
        end
        bus.byte_valid = 1'b0;
        bus.last       = 1'b0;
        bus.start      = 1'b0;
    endtask

    // Reference: word w holds bytes 4w..4w+3 big-endian, missing bytes zero,
    // written at address w; memory holds CAP words, a longer program overflows.
    task automatic run_load();
        int          n, nw;
        bit          ovf, acc;
        logic [31:0] word;
        n   = prog.size();
        ovf = (n > 4 * CAP);
        nw  = ovf ? CAP : (n + 3) / 4;
        for (int w = 0; w < nw; w++) begin
            word = 32'h0;
            for (int k = 0; k < 4; k++) begin
                if (4 * w + k < n) word = word | (32'(prog[4 * w + k]) << (24 - 8 * k));
            end
            exp_addr_q.push_back(w);
            exp_data_q.push_back(word);
        end
        pulse_start();
        for (int i = 0; i < n; i++) begin
            send_byte(prog[i], (i == n - 1), acc);
            chk(i < 4 * CAP ? "byte_accepted" : "byte_refused", 64'(acc),
                (i < 4 * CAP) ? 64'd1 : 64'd0);
        end
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (bus.done) break;
        end
        chk("done",       64'(bus.done), 1);
        chk("overflow",   64'(bus.overflow), 64'(ovf));
        chk("word_count", 64'(bus.word_count), 64'(nw));
        chk("busy_low",   64'(bus.busy), 0);
        chk("ready_low",  64'(bus.byte_ready), 0);
        chk("writes_seen_all", 64'(exp_data_q.size()), 0);
    endtask

    initial begin
        bit acc;
        bus.start      = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        bus.last       = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        #2 rst_n = 1'b1;

        prog.delete();
        prog.push_back(8'h8C); prog.push_back(8'h01);
        prog.push_back(8'h00); prog.push_back(8'h04);
        run_load();

        prog.delete();
        for (int i = 0; i < 8; i++) prog.push_back(8'(i));
        run_load();

        prog.delete();
        prog.push_back(8'hAA); prog.push_back(8'hBB);
        run_load();

        prog.delete();
        for (int i = 0; i < 17; i++) prog.push_back(8'(8'h40 + i));
        run_load();

        // Reset in the middle of a word must discard it without a write.
        pulse_start();
        send_byte(8'h55, 1'b0, acc);
        send_byte(8'h66, 1'b0, acc);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_idle_outputs("midreset");
        @(negedge clk);
        #2 rst_n = 1'b1;
        prog.delete();
        prog.push_back(8'h11); prog.push_back(8'h22);
        prog.push_back(8'h33); prog.push_back(8'h44);
        run_load();

        for (int r = 0; r < 14; r++) begin
            int len;
            len = $urandom_range(1, 20);
            prog.delete();
            for (int i = 0; i < len; i++) prog.push_back(8'($urandom));
            run_load();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning the instruction word width; only 32 is supported.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 8, meaning the instruction memory word-address width.
REQ-003 The block SHALL have port i_clk, input, 1 bit, the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port i_rst_n, input, 1 bit, an asynchronous active-low reset.
REQ-005 The block SHALL have port i_start, input, 1 bit, a pulse that begins a program load.
REQ-006 The block SHALL have port i_byte_valid, input, 1 bit, meaning i_byte carries a program byte.
REQ-007 The block SHALL have port i_byte, input, 8 bits, the program byte.
REQ-008 The block SHALL have port i_last, input, 1 bit, marking the byte being transferred as the final byte of the program.
REQ-009 The block SHALL have port o_byte_ready, output, 1 bit, meaning the loader accepts a byte this cycle.
REQ-010 The block SHALL have port o_we, output, 1 bit, the instruction memory write strobe.
REQ-011 The block SHALL have port o_addr, output, ADDR_WIDTH bits, the word address to write.
REQ-012 The block SHALL have port o_data, output, DATA_WIDTH bits, the word to write.
REQ-013 The block SHALL have port o_busy, output, 1 bit, high while a load is in progress.
REQ-014 The block SHALL have port o_done, output, 1 bit, high once a load has finished.
REQ-015 The block SHALL have port o_overflow, output, 1 bit, meaning the program exceeded the memory size.
REQ-016 The block SHALL have port o_word_count, output, ADDR_WIDTH+1 bits, the number of words written in the current load.

Function
REQ-017 The block SHALL implement FSM states IDLE, COLLECT, WRITE and DONE.
REQ-018 In IDLE or DONE, i_start SHALL clear the address, byte counter, word count, o_done and o_overflow, and SHALL move the FSM to COLLECT.
REQ-019 In COLLECT, o_byte_ready SHALL be 1; it SHALL be 0 in every other state.
REQ-020 A byte SHALL be accepted only on a cycle where i_byte_valid and o_byte_ready are both 1.
REQ-021 Bytes SHALL be packed big-endian: the first accepted byte goes to bits [31:24] and the fourth to bits [7:0].
REQ-022 Acceptance of the 4th byte of a word, or of any byte with i_last=1, SHALL move the FSM to WRITE on the next edge.
REQ-023 For a partial word ended by i_last, the unfilled low bytes SHALL be written as 0x00.
REQ-024 In WRITE, o_we SHALL be 1 for exactly one cycle, with o_addr and o_data stable; latency is one cycle from the final byte accepted to o_we.
REQ-025 o_word_count SHALL increment in the WRITE cycle.
REQ-026 After WRITE, the FSM SHALL go to DONE if the word held i_last.
REQ-027 After WRITE, if o_addr equals 2^ADDR_WIDTH-1 and the word did not hold i_last, the FSM SHALL go to DONE and set o_overflow=1; the address SHALL NOT wrap.
REQ-028 In all other cases after WRITE, o_addr SHALL increment and the FSM SHALL return to COLLECT.
REQ-029 o_busy SHALL be 1 in COLLECT and WRITE; o_done SHALL be 1 in DONE and held until the next i_start.
REQ-030 i_start SHALL be ignored in COLLECT and WRITE.
REQ-031 i_last with i_byte_valid=0 SHALL have no effect.
REQ-032 When o_we=0, o_data SHALL hold its last value.

Reset
REQ-033 Asserting i_rst_n low SHALL immediately put the FSM in IDLE and set all outputs to 0, including a reset mid-load; a partially assembled word SHALL be discarded with no write issued.

Structure
REQ-034 The FSM state encoding and the BYTES_PER_WORD=4 constant SHALL reside in the shared package mips_pkg.
REQ-035 Byte shifting and zero-padding SHALL be a sub-module named word_assembler; the FSM and counters SHALL stay in imem_loader.

Verification
REQ-036 i_start, then bytes 8C,01,00,04 with i_last on the 4th -> one o_we, o_addr=0, o_data=0x8C010004, o_done=1, o_word_count=1.
REQ-037 Eight bytes 00..07 with i_last on 07 -> writes 0x00010203 at address 0 and 0x04050607 at address 1, each o_we exactly one cycle.
REQ-038 Bytes AA,BB with i_last on BB -> o_data=0xAABB0000 at address 0, then o_done=1.
REQ-039 ADDR_WIDTH=2 with 17 bytes sent -> 4 words written at addresses 0..3, o_overflow=1, o_done=1, o_byte_ready=0, and byte 17 never accepted.
REQ-040 i_rst_n pulled low after 2 bytes of a word, then i_start and bytes 11,22,33,44 with i_last -> o_addr=0, o_data=0x11223344, and no earlier write.
REQ-041 i_byte_valid toggled 1/0 with i_start asserted during COLLECT -> packing is unaffected by gaps and the restart is ignored.
